// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word
// geometry and the base-address alignment helper.
package inst_mem_loader_pkg;

  typedef enum logic [1:0] {
    LDR_IDLE    = 2'd0,
    LDR_COLLECT = 2'd1,
    LDR_WRITE   = 2'd2,
    LDR_DONE    = 2'd3
  } ldr_state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam logic [ADDR_W-1:0] WORD_STRIDE = ADDR_W'(WORD_BYTES);

  // Word-align a byte address by dropping the two byte-offset bits.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Packs a little-endian byte stream into words: the first byte of a word lands
// in the low lane. The finished word is published only when its last byte arrives.
module inst_mem_loader_byte_packer
  import inst_mem_loader_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int DATA_W = WORD_BYTES * BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [DATA_W-1:0] word,
  output logic              full
);

  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0]         byte_idx;
  logic [DATA_W-BYTE_W-1:0] stage;

  assign full = push && (byte_idx == LAST_IDX);

  // Lower bytes collect in stage; word only changes when the last byte lands,
  // so the value presented to memory stays stable between writes.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      byte_idx <= '0;
      stage    <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (push) begin
      if (full) begin
        word     <= {in_byte, stage};
        byte_idx <= '0;
      end else begin
        stage[BYTE_W*byte_idx +: BYTE_W] <= in_byte;
        byte_idx                         <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Write side of the instruction memory: streams bytes in over valid/ready and
// writes packed little-endian words to consecutive word addresses.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  ldr_state_e       state, state_next;
  logic [31:0]      cur_addr;
  logic [CNT_W-1:0] words_left;
  logic             push;
  logic             packer_clear;
  logic             word_full;

  assign push         = in_valid && in_ready;
  assign packer_clear = ((state == LDR_IDLE) && start) || (state == LDR_WRITE);

  inst_mem_loader_byte_packer #(
    .BYTE_W (BYTE_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (packer_clear),
    .push    (push),
    .in_byte (in_byte),
    .word    (mem_wdata),
    .full    (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LDR_IDLE;
    else     state <= state_next;
  end

  // Outputs depend on state only, so no input reaches an output in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      LDR_IDLE: begin
        if (start) state_next = (word_count != '0) ? LDR_COLLECT : LDR_DONE;
      end
      LDR_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_full) state_next = LDR_WRITE;
      end
      LDR_WRITE: begin
        mem_we     = 1'b1;
        busy       = 1'b1;
        state_next = (words_left == CNT_W'(1)) ? LDR_DONE : LDR_COLLECT;
      end
      LDR_DONE: begin
        done       = 1'b1;
        state_next = LDR_IDLE;
      end
      default: state_next = LDR_IDLE;
    endcase
  end

  // mem_addr is captured on entry to WRITE so it holds while cur_addr advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      words_left <= '0;
      mem_addr   <= '0;
    end else begin
      unique case (state)
        LDR_IDLE: begin
          if (start && (word_count != '0)) begin
            cur_addr   <= align_word(base_addr);
            words_left <= word_count;
          end
        end
        LDR_COLLECT: begin
          if (word_full) mem_addr <= cur_addr;
        end
        LDR_WRITE: begin
          cur_addr   <= cur_addr + WORD_STRIDE;
          words_left <= words_left - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: behavioural instruction memory indexed by
// mem_addr[19:2], a write log, and one task per scenario.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata;

  int tests_run = 0;
  int failed    = 0;

  inst_mem_loader #(.DATA_W(32), .BYTE_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:262143];
  always @(posedge clk) if (mem_we) imem[mem_addr[19:2]] <= mem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    int          cyc;
  } wr_t;

  wr_t log_q[$];
  int  cyc      = 0;
  int  done_cnt = 0;
  int  busy_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we) log_q.push_back('{addr: mem_addr, data: mem_wdata, rdy: in_ready, cyc: cyc});
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  logic [31:0] prog [16] = '{
    32'h00000093, 32'h00100113, 32'h002081B3, 32'h00310233,
    32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 32'h12345678,
    32'h87654321, 32'hFFFFFFFF, 32'h00000000, 32'hA5A55A5A,
    32'h01020304, 32'hF0E0D0C0, 32'h7FFFFFFF, 32'h80000001
  };

  int gaps [12] = '{0, 2, 1, 0, 3, 0, 1, 0, 0, 2, 1, 0};

  // All tasks start and end just after a falling edge.
  task automatic push_byte(input logic [7:0] b, input int gap);
    logic r;
    logic ok;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    ok       = 1'b0;
    for (int t = 0; t < 100; t++) begin
      r = in_ready;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL push_timeout: byte %h not accepted, got in_ready=%b expected 1", b, in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap0, input int gap1,
                           input int gap2, input int gap3);
    push_byte(w[7:0],   gap0);
    push_byte(w[15:8],  gap1);
    push_byte(w[23:16], gap2);
    push_byte(w[31:24], gap3);
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!ok) begin
      failed++;
      $display("FAIL done_timeout: got done=%b expected 1", done);
    end
  endtask

  task automatic expect_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    tests_run++;
    if ({mem_we, in_ready, busy} !== 3'b101) begin
      failed++;
      $display("FAIL %s_ctrl: got we/ready/busy=%b expected 101", name, {mem_we, in_ready, busy});
    end
    tests_run++;
    if (mem_addr !== addr) begin
      failed++;
      $display("FAIL %s_addr: got %h expected %h", name, mem_addr, addr);
    end
    tests_run++;
    if (mem_wdata !== data) begin
      failed++;
      $display("FAIL %s_data: got %h expected %h", name, mem_wdata, data);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({in_ready, mem_we, busy, done} !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failed++;
      $display("FAIL reset_outputs: got rdy/we/busy/done=%b addr=%h data=%h expected 0000 0 0",
               {in_ready, mem_we, busy, done}, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    int w0;
    w0 = log_q.size();
    do_start(32'h0, 16'd1);
    send_word(32'h12345678, 0, 0, 0, 0);
    expect_write("single", 32'h0, 32'h12345678);
    @(negedge clk);
    tests_run++;
    if ({done, mem_we, busy} !== 3'b100) begin
      failed++;
      $display("FAIL single_done: got done/we/busy=%b expected 100", {done, mem_we, busy});
    end
    @(negedge clk);
    tests_run++;
    if ({done, busy, in_ready} !== 3'b000 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h0) begin
      failed++;
      $display("FAIL single_idle_hold: got done/busy/rdy=%b addr=%h data=%h expected 000 0 12345678",
               {done, busy, in_ready}, mem_addr, mem_wdata);
    end
    tests_run++;
    if (log_q.size() - w0 != 1) begin
      failed++;
      $display("FAIL single_count: got %0d writes expected 1", log_q.size() - w0);
    end
  endtask

  task automatic test_gaps();
    int w0;
    logic [31:0] words [3] = '{32'hA1B2C3D4, 32'h0BADF00D, 32'hCAFEBABE};
    w0 = log_q.size();
    do_start(32'h100, 16'd3);
    for (int k = 0; k < 3; k++) begin
      send_word(words[k], gaps[4*k], gaps[4*k+1], gaps[4*k+2], gaps[4*k+3]);
      expect_write($sformatf("gaps_w%0d", k), 32'h100 + 32'(4*k), words[k]);
    end
    @(negedge clk);
    wait_done();
    @(negedge clk);
    tests_run++;
    if (log_q.size() - w0 != 3) begin
      failed++;
      $display("FAIL gaps_count: got %0d writes expected 3", log_q.size() - w0);
    end
    for (int k = 0; k < 3 && w0 + k < log_q.size(); k++) begin
      tests_run++;
      if (log_q[w0+k].addr !== 32'h100 + 32'(4*k) || log_q[w0+k].rdy !== 1'b0) begin
        failed++;
        $display("FAIL gaps_log%0d: got addr=%h rdy=%b expected %h 0",
                 k, log_q[w0+k].addr, log_q[w0+k].rdy, 32'h100 + 32'(4*k));
      end
    end
  endtask

  task automatic test_unaligned_and_zero();
    int w0;
    int b0;
    do_start(32'h203, 16'd2);
    send_word(32'h44332211, 0, 1, 0, 0);
    expect_write("unal_w0", 32'h200, 32'h44332211);
    send_word(32'h88776655, 0, 0, 0, 0);
    expect_write("unal_w1", 32'h204, 32'h88776655);
    @(negedge clk);
    wait_done();
    @(negedge clk);
    w0 = log_q.size();
    b0 = busy_cnt;
    do_start(32'h700, 16'd0);
    tests_run++;
    if ({done, busy, mem_we} !== 3'b100) begin
      failed++;
      $display("FAIL zero_done: got done/busy/we=%b expected 100", {done, busy, mem_we});
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || log_q.size() != w0 || busy_cnt != b0) begin
      failed++;
      $display("FAIL zero_quiet: got done=%b writes=%0d busy_cycles=%0d expected 0 0 0",
               done, log_q.size() - w0, busy_cnt - b0);
    end
  endtask

  task automatic test_reset_mid_word();
    int w0;
    int d0;
    w0 = log_q.size();
    d0 = done_cnt;
    do_start(32'h300, 16'd2);
    send_word(32'h11223344, 0, 0, 0, 0);
    expect_write("rstmid_w0", 32'h300, 32'h11223344);
    push_byte(8'hAA, 0);
    push_byte(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({in_ready, mem_we, busy, done} !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failed++;
      $display("FAIL rstmid_outputs: got rdy/we/busy/done=%b addr=%h data=%h expected 0000 0 0",
               {in_ready, mem_we, busy, done}, mem_addr, mem_wdata);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (log_q.size() - w0 != 1 || done_cnt != d0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_quiet: got writes=%0d dones=%0d busy=%b expected 1 0 0",
               log_q.size() - w0, done_cnt - d0, busy);
    end
    do_start(32'h400, 16'd1);
    send_word(32'hDEADBEEF, 0, 0, 0, 0);
    expect_write("rstmid_new", 32'h400, 32'hDEADBEEF);
    @(negedge clk);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_wrap_ignored_start();
    int w0;
    int d0;
    w0 = log_q.size();
    d0 = done_cnt;
    do_start(32'hFFFFFFFC, 16'd2);
    push_byte(8'h01, 0);
    push_byte(8'h02, 0);
    do_start(32'h500, 16'd5);
    push_byte(8'h03, 0);
    push_byte(8'h04, 0);
    expect_write("wrap_w0", 32'hFFFFFFFC, 32'h04030201);
    send_word(32'h55AA55AA, 0, 0, 0, 0);
    expect_write("wrap_w1", 32'h0, 32'h55AA55AA);
    @(negedge clk);
    wait_done();
    repeat (2) @(negedge clk);
    tests_run++;
    if (log_q.size() - w0 != 2 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL wrap_summary: got writes=%0d dones=%0d busy=%b expected 2 1 0",
               log_q.size() - w0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = log_q.size();
    do_start(32'h1000, 16'd16);
    for (int k = 0; k < 16; k++) send_word(prog[k], 0, 0, 0, 0);
    @(negedge clk);
    wait_done();
    @(negedge clk);
    tests_run++;
    if (log_q.size() - w0 != 16) begin
      failed++;
      $display("FAIL b2b_count: got %0d writes expected 16", log_q.size() - w0);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (imem[18'h400 + 18'(k)] !== prog[k]) begin
        failed++;
        $display("FAIL b2b_mem%0d: got %h expected %h", k, imem[18'h400 + 18'(k)], prog[k]);
      end
    end
    for (int k = 1; k < 16 && w0 + k < log_q.size(); k++) begin
      tests_run++;
      if (log_q[w0+k].cyc - log_q[w0+k-1].cyc != 5) begin
        failed++;
        $display("FAIL b2b_spacing%0d: got %0d cycles expected 5",
                 k, log_q[w0+k].cyc - log_q[w0+k-1].cyc);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_gaps();
    test_unaligned_and_zero();
    test_reset_mid_word();
    test_wrap_ignored_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
